// File: rtl/x2_pkg.sv
// Shared word width and word type for the x2 result collector.
package x2_pkg;
  localparam int X2_WORD_W = 7;
  typedef logic [X2_WORD_W-1:0] x2_word_t;
endpackage

// File: rtl/x2_fifo.sv
// First-word fall-through FIFO; full/empty come from the occupancy count alone.
module x2_fifo #(
  parameter int  DEPTH  = 4,
  parameter type word_t = logic [6:0]
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  word_t                        wdata,
  output word_t                        rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  word_t          mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (reset_n && push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign level = level_q;
endmodule

// File: rtl/x2_result_collector.sv
// Packs the x2 output bits into a word, drops repeats, and queues results for a consumer.
module x2_result_collector
  import x2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DEDUP = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic                         po0,
  input  logic                         po1,
  input  logic                         po2,
  input  logic                         po3,
  input  logic                         po4,
  input  logic                         po5,
  input  logic                         po6,
  output logic                         in_ready,
  output logic                         out_valid,
  output x2_word_t                     out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);
  localparam int LW = $clog2(DEPTH+1);

  x2_word_t word;
  x2_word_t last_word_q, last_word_d;
  logic     last_vld_q, last_vld_d;
  logic     overflow_q, overflow_d;
  logic     accept, is_dup, push, pop;

  assign word      = {po6, po5, po4, po3, po2, po1, po0};
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign accept    = in_valid & in_ready;
  assign is_dup    = (DEDUP != 0) && last_vld_q && (word == last_word_q);
  assign push      = accept & ~is_dup;
  assign pop       = out_valid & out_ready;

  always_comb begin
    last_word_d = last_word_q;
    last_vld_d  = last_vld_q;
    overflow_d  = overflow_q;
    if (push) begin
      last_word_d = word;
      last_vld_d  = 1'b1;
    end
    if (in_valid && !in_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_vld_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      last_vld_q <= last_vld_d;
      overflow_q <= overflow_d;
    end
  end

  // last_word survives reset and drain; last_vld alone gates the comparison.
  always_ff @(posedge clock) begin
    last_word_q <= last_word_d;
  end

  assign overflow = overflow_q;

  x2_fifo #(
    .DEPTH  (DEPTH),
    .word_t (x2_word_t)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (word),
    .rdata   (out_data),
    .level   (level)
  );
endmodule

// File: tb/tb_x2_result_collector.sv
// Self-checking bench: a DEDUP=1 and a DEDUP=0 collector share stimulus and are compared to a queue model.
module tb_x2_result_collector;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] w = '0;

  logic          ir  [2];
  logic          ov  [2];
  logic [6:0]    od  [2];
  logic [LW-1:0] lv  [2];
  logic          ofl [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [6:0] mfifo [2][0:15];
  int         mcnt  [2];
  logic       mlv   [2];
  logic [6:0] mlw   [2];
  logic       mof   [2];

  always #5 clock = ~clock;

  x2_result_collector #(.DEPTH(DEPTH), .DEDUP(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .po0(w[0]), .po1(w[1]), .po2(w[2]), .po3(w[3]), .po4(w[4]), .po5(w[5]), .po6(w[6]),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .level(lv[0]), .overflow(ofl[0]));

  x2_result_collector #(.DEPTH(DEPTH), .DEDUP(0)) dut_nd (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .po0(w[0]), .po1(w[1]), .po2(w[2]), .po3(w[3]), .po4(w[4]), .po5(w[5]), .po6(w[6]),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .level(lv[1]), .overflow(ofl[1]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list per instance, updated from the inputs seen at each edge.
  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        mcnt[m] = 0;
        mlv[m]  = 1'b0;
        mof[m]  = 1'b0;
      end else begin
        bit full, do_pop, do_push;
        full    = (mcnt[m] == DEPTH);
        do_pop  = (mcnt[m] != 0) && out_ready;
        do_push = in_valid && !full && !(m == 0 && mlv[m] && w == mlw[m]);
        if (in_valid && full) mof[m] = 1'b1;
        if (do_pop) begin
          for (int i = 0; i < 15; i++) mfifo[m][i] = mfifo[m][i+1];
          mcnt[m]--;
        end
        if (do_push) begin
          mfifo[m][mcnt[m]] = w;
          mcnt[m]++;
          mlw[m] = w;
          mlv[m] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("level[%0d]", m), int'(lv[m]), mcnt[m]);
        check($sformatf("in_ready[%0d]", m), int'(ir[m]), int'(mcnt[m] != DEPTH));
        check($sformatf("out_valid[%0d]", m), int'(ov[m]), int'(mcnt[m] != 0));
        check($sformatf("overflow[%0d]", m), int'(ofl[m]), int'(mof[m]));
        if (mcnt[m] != 0) check($sformatf("out_data[%0d]", m), int'(od[m]), int'(mfifo[m][0]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [6:0] wd, input logic ordy);
    in_valid  = iv;
    w         = wd;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b0, 7'h00, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] exp_head;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("rst_in_ready", int'(ir[0]), 1);
    check("rst_out_valid", int'(ov[0]), 0);
    check("rst_level", int'(lv[0]), 0);
    check("rst_overflow", int'(ofl[0]), 0);

    // Single push: visible only after the edge.
    drive(1'b1, 7'h05, 1'b0);
    #1;
    check("no_same_cycle_valid", int'(ov[0]), 0);
    tick();
    drive(1'b0, 7'h00, 1'b0);
    check("push1_valid", int'(ov[0]), 1);
    check("push1_data", int'(od[0]), 'h05);
    check("push1_level", int'(lv[0]), 1);

    // Dedup of a repeated word, then drain.
    drive(1'b1, 7'h05, 1'b0); tick();
    drive(1'b1, 7'h12, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b0);
    check("dedup_level", int'(lv[0]), 2);
    check("nodedup_level", int'(lv[1]), 3);
    drive(1'b0, 7'h00, 1'b1);
    check("dedup_pop0", int'(od[0]), 'h05);
    tick();
    check("dedup_pop1", int'(od[0]), 'h12);
    tick();
    drive(1'b0, 7'h00, 1'b0);
    check("dedup_drained", int'(lv[0]), 0);

    // Overflow on the fifth word.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 7'(i), 1'b0);
      tick();
    end
    drive(1'b0, 7'h00, 1'b0);
    check("full_level", int'(lv[0]), 4);
    check("full_in_ready", int'(ir[0]), 0);
    check("full_overflow", int'(ofl[0]), 1);
    drive(1'b0, 7'h00, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("full_pop%0d", i), int'(od[0]), i);
      tick();
    end
    drive(1'b0, 7'h00, 1'b0);
    check("full_drained", int'(lv[0]), 0);
    check("overflow_sticky", int'(ofl[0]), 1);

    // Streaming at level 2 across pointer wrap.
    do_reset();
    drive(1'b1, 7'h10, 1'b0); tick();
    drive(1'b1, 7'h11, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 7'(8'h20 + i), 1'b1);
      exp_head = (i == 0) ? 7'h10 : (i == 1) ? 7'h11 : 7'(8'h20 + i - 2);
      check($sformatf("stream_head%0d", i), int'(od[0]), int'(exp_head));
      tick();
      check($sformatf("stream_level%0d", i), int'(lv[0]), 2);
    end

    // Reset mid-stream; the pre-reset last word must not suppress the next push.
    drive(1'b1, 7'h05, 1'b0); tick();
    check("pre_reset_level", int'(lv[0]), 3);
    reset_n = 1'b0;
    drive(1'b1, 7'h05, 1'b0);
    tick();
    reset_n = 1'b1;
    drive(1'b0, 7'h00, 1'b0);
    check("post_reset_level", int'(lv[0]), 0);
    check("post_reset_valid", int'(ov[0]), 0);
    check("post_reset_overflow", int'(ofl[0]), 0);
    drive(1'b1, 7'h05, 1'b0); tick();
    drive(1'b0, 7'h00, 1'b0);
    check("post_reset_push", int'(lv[0]), 1);

    // No dedup: identical words all stored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'h7F, 1'b0);
      tick();
    end
    drive(1'b0, 7'h00, 1'b0);
    check("nd_level", int'(lv[1]), 3);
    check("d_level", int'(lv[0]), 1);
    drive(1'b0, 7'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("nd_pop%0d", i), int'(od[1]), 'h7F);
      tick();
    end
    drive(1'b0, 7'h00, 1'b0);

    // Randomized traffic with a small word alphabet so repeats are common.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      drive(1'($urandom_range(0, 2) != 0), 7'($urandom_range(0, 3) * 37), 1'($urandom_range(0, 1)));
      tick();
    end
    reset_n = 1'b1;
    drive(1'b0, 7'h00, 1'b0);
    tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
